char_ram_writer: RTL and testbench

CHAR_RAM_WRITER -- requirements
Module: char_ram_writer

---
 rtl/char_ram_writer_pkg.sv | 14 +
 rtl/char_cursor.sv | 39 +++
 rtl/char_ram_writer.sv | 91 +++++++++
 tb/tb_char_ram_writer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/char_ram_writer_pkg.sv
// char_ram_writer_pkg: control-code constants, FSM state encoding and character classification shared by the text writer
package char_ram_writer_pkg;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  function automatic logic is_printable(input logic [7:0] c);
    return c >= CH_SPACE && c <= CH_TILDE;
  endfunction
endpackage

// File: rtl/char_cursor.sv
// char_cursor: row/col cursor counters with advance, newline, carriage return, backspace and home
// Ports: clk/rst (async active-high), i_adv advance one cell, i_nl next row (col kept),
//        i_cr col to 0, i_bs col-1 unless at col 0, i_home to (0,0); o_row/o_col current position.
// Both fields are powers of two wide, so natural counter overflow gives the required wrap.
module char_cursor #(
  parameter int ROW_W = 4,
  parameter int COL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_adv,
  input  logic             i_nl,
  input  logic             i_cr,
  input  logic             i_bs,
  input  logic             i_home,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col
);
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_home) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      r_col <= r_col + 1'b1;
      if (&r_col) r_row <= r_row + 1'b1;
    end else if (i_nl)
      r_row <= r_row + 1'b1;
    else if (i_cr)
      r_col <= '0;
    else if (i_bs && r_col != '0)
      r_col <= r_col - 1'b1;
  assign o_row = r_row;
  assign o_col = r_col;
endmodule

// File: rtl/char_ram_writer.sv
// char_ram_writer: turns a character stream into writes on a text buffer's write port, with cursor control and screen clear
// Ports: wclk clock, rst async active-high reset; cdata/cvalid/cready character stream in;
//        clr clear-screen pulse; waddr/wdata/we registered buffer write port; busy high while clearing;
//        cur_row/cur_col current cursor position.
module char_ram_writer
  import char_ram_writer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int COLS       = 16,
  localparam int ROW_W     = $clog2((2 ** ADDR_WIDTH) / COLS),
  localparam int COL_W     = $clog2(COLS)
) (
  input  logic                  wclk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] cdata,
  input  logic                  cvalid,
  output logic                  cready,
  input  logic                  clr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  we,
  output logic                  busy,
  output logic [ROW_W-1:0]      cur_row,
  output logic [COL_W-1:0]      cur_col
);
  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we;
  logic [7:0]            w_code;
  logic                  w_cls;
  logic                  w_acc;
  logic                  w_print;
  logic                  w_bs;
  logic                  w_start;
  logic                  w_last;
  assign w_code  = cdata[7:0];
  // codes with any bit above bit 7 set fall into the "other" class
  assign w_cls   = (cdata >> 8) == '0;
  assign cready  = r_state == ST_IDLE && !clr;
  assign w_acc   = cvalid && cready;
  assign w_print = w_acc && w_cls && is_printable(w_code);
  assign w_bs    = w_acc && w_cls && w_code == CH_BS;
  assign w_start = r_state == ST_IDLE && (clr || (w_acc && w_cls && w_code == CH_FF));
  assign w_last  = r_state == ST_CLEAR && &r_cnt;
  assign busy    = r_state == ST_CLEAR;
  char_cursor #(.ROW_W(ROW_W), .COL_W(COL_W)) u_cursor (
    .clk   (wclk),
    .rst   (rst),
    .i_adv (w_print),
    .i_nl  (w_acc && w_cls && w_code == CH_LF),
    .i_cr  (w_acc && w_cls && w_code == CH_CR),
    .i_bs  (w_bs),
    .i_home(w_last),
    .o_row (cur_row),
    .o_col (cur_col)
  );
  // row/col concatenation equals row*COLS+col because COLS is a power of two
  always_ff @(posedge wclk or posedge rst)
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (r_state == ST_CLEAR) begin
      r_we    <= 1'b1;
      r_waddr <= r_cnt;
      r_wdata <= DATA_WIDTH'(CH_SPACE);
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) r_state <= ST_IDLE;
    end else if (w_start) begin
      r_we    <= 1'b0;
      r_cnt   <= '0;
      r_state <= ST_CLEAR;
    end else if (w_print) begin
      r_we    <= 1'b1;
      r_waddr <= {cur_row, cur_col};
      r_wdata <= cdata;
    end else if (w_bs && cur_col != '0) begin
      r_we    <= 1'b1;
      r_waddr <= {cur_row, cur_col - 1'b1};
      r_wdata <= DATA_WIDTH'(CH_SPACE);
    end else
      r_we    <= 1'b0;
  assign waddr = r_waddr;
  assign wdata = r_wdata;
  assign we    = r_we;
endmodule

// File: tb/tb_char_ram_writer.sv
// tb_char_ram_writer: directed self-checking bench for char_ram_writer with default parameters
module tb_char_ram_writer;
  logic       wclk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cdata = '0;
  logic       cvalid = 1'b0;
  logic       cready;
  logic       clr = 1'b0;
  logic [7:0] waddr;
  logic [7:0] wdata;
  logic       we;
  logic       busy;
  logic [3:0] cur_row;
  logic [3:0] cur_col;
  int n_tests = 0;
  int n_fail = 0;
  char_ram_writer dut (
    .wclk(wclk), .rst(rst), .cdata(cdata), .cvalid(cvalid), .cready(cready), .clr(clr),
    .waddr(waddr), .wdata(wdata), .we(we), .busy(busy), .cur_row(cur_row), .cur_col(cur_col)
  );
  always #5 wclk = ~wclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] c, input logic exp_we, input logic [7:0] exp_a, input logic [7:0] exp_d);
    cdata = c;
    cvalid = 1'b1;
    @(negedge wclk);
    cvalid = 1'b0;
    chk("we", we, exp_we);
    if (exp_we) begin
      chk("waddr", waddr, exp_a);
      chk("wdata", wdata, exp_d);
    end
  endtask
  task automatic cur(input string tag, input logic [3:0] r, input logic [3:0] c);
    chk({tag, "_row"}, cur_row, r);
    chk({tag, "_col"}, cur_col, c);
  endtask
  initial begin
    int busy_n, wr_n, errs;
    @(negedge wclk);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", busy, 0);
    cur("rst", 0, 0);
    rst = 1'b0;
    @(negedge wclk);
    chk("rst_cready", cready, 1);
    send("A", 1, 8'h00, 8'h41);
    send("B", 1, 8'h01, 8'h42);
    cur("ab", 0, 2);
    @(negedge wclk);
    chk("idle_we", we, 0);
    for (int i = 2; i < 15; i++) send(8'h61, 1, 8'(i), 8'h61);
    cur("pre_wrap", 0, 15);
    for (int i = 0; i < 16; i++) send("X", 1, 8'(15 + i), "X");
    cur("wrap", 1, 15);
    send(8'h0D, 0, 0, 0);
    for (int i = 0; i < 14; i++) send(8'h0A, 0, 0, 0);
    for (int i = 0; i < 3; i++) send("a", 1, 8'(8'hF0 + i), "a");
    cur("r15", 15, 3);
    send(8'h0A, 0, 0, 0);
    cur("lf_wrap", 0, 3);
    send(8'h0D, 0, 0, 0);
    cur("cr", 0, 0);
    send(8'h0A, 0, 0, 0);
    send(8'h0A, 0, 0, 0);
    for (int i = 0; i < 5; i++) send(8'(8'h30 + i), 1, 8'(8'h20 + i), 8'(8'h30 + i));
    cur("r2", 2, 5);
    send(8'h08, 1, 8'h24, 8'h20);
    cur("bs", 2, 4);
    send(8'h0D, 0, 0, 0);
    send(8'h08, 0, 0, 0);
    cur("bs0", 2, 0);
    send(8'h01, 0, 0, 0);
    send(8'h7F, 0, 0, 0);
    cur("other", 2, 0);
    cdata = "Z";
    cvalid = 1'b1;
    clr = 1'b1;
    #1;
    chk("clr_cready", cready, 0);
    @(negedge wclk);
    clr = 1'b0;
    cvalid = 1'b0;
    busy_n = 0;
    wr_n = 0;
    errs = 0;
    for (int i = 0; i < 400 && (busy || wr_n < 256); i++) begin
      if (busy) busy_n++;
      if (we) begin
        if (waddr != 8'(wr_n) || wdata != 8'h20) errs++;
        wr_n++;
      end
      clr = i == 50;
      @(negedge wclk);
      clr = 1'b0;
    end
    chk("clr_busy_cycles", busy_n, 256);
    chk("clr_writes", wr_n, 256);
    chk("clr_bad_writes", errs, 0);
    chk("clr_cready_after", cready, 1);
    cur("clr", 0, 0);
    @(negedge wclk);
    chk("clr_we_after", we, 0);
    send(8'h0C, 0, 0, 0);
    chk("ff_busy", busy, 1);
    wr_n = 0;
    for (int i = 0; i < 200 && wr_n < 100; i++) begin
      @(negedge wclk);
      if (we) wr_n++;
    end
    chk("ff_writes", wr_n, 100);
    rst = 1'b1;
    #1;
    chk("abort_we", we, 0);
    chk("abort_busy", busy, 0);
    cur("abort", 0, 0);
    @(negedge wclk);
    rst = 1'b0;
    @(negedge wclk);
    chk("abort_cready", cready, 1);
    send("Q", 1, 8'h00, "Q");
    cur("post", 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
